// File: rtl/imsic_setipnum_ctrl_pkg.sv
// Shared IMSIC definitions: interrupt-file page layout, setipnum register offsets,
// and the message record carried from the write decoder to the interrupt files.
package imsic_pkg;

    localparam int unsigned IMSIC_PAGE_SHIFT = 12;
    localparam logic [11:0] SETEIPNUM_LE_OFF = 12'h000;
    localparam logic [11:0] SETEIPNUM_BE_OFF = 12'h004;

    // Field widths are sized for the largest legal configuration; narrower
    // configurations zero-fill the upper bits.
    localparam int unsigned IMSIC_HART_W_MAX = 14;
    localparam int unsigned IMSIC_FILE_W_MAX = 6;
    localparam int unsigned IMSIC_ID_W_MAX   = 11;

    typedef struct packed {
        logic [IMSIC_HART_W_MAX-1:0] hart;
        logic [IMSIC_FILE_W_MAX-1:0] file;
        logic [IMSIC_ID_W_MAX-1:0]   id;
    } imsic_msi_t;

    function automatic logic [31:0] imsic_bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/imsic_msi_fifo.sv
// Generic typed FIFO; a push is visible at the head one cycle later.
// Backpressure: push ignored when full, pop ignored when empty; head reads as zero when empty.
module imsic_msi_fifo #(
    parameter type         T     = logic,
    parameter int unsigned Depth = 4
) (
    input  logic i_clk,
    input  logic ni_rst,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int unsigned AW = $clog2(Depth);

    T           mem_q [Depth];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    // The extra MSB tells a full buffer apart from an empty one.
    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_data  = o_empty ? T'('0) : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/imsic_setipnum_ctrl.sv
// IMSIC setipnum write front-end: decodes M and S/VS page writes into buffered messages.
// Message visible one cycle after acceptance; requests stall (reads included) while the buffer is full.
module imsic_setipnum_ctrl
    import imsic_pkg::*;
#(
    parameter int unsigned NrHarts   = 4,
    parameter int unsigned NrVsFiles = 1,
    parameter int unsigned NrSources = 64,
    parameter logic [31:0] MBaseAddr = 32'h2400_0000,
    parameter logic [31:0] SBaseAddr = 32'h2800_0000,
    parameter int unsigned FifoDepth = 4,
    localparam int unsigned HartW    = (NrHarts > 1) ? $clog2(NrHarts) : 1,
    localparam int unsigned FileW    = $clog2(NrVsFiles + 2),
    localparam int unsigned IdW      = $clog2(NrSources)
) (
    input  logic             i_clk,
    input  logic             ni_rst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_req_we,
    input  logic [31:0]      i_req_addr,
    input  logic [31:0]      i_req_wdata,
    output logic             o_rsp_valid,
    output logic [31:0]      o_rsp_rdata,
    output logic             o_msi_valid,
    input  logic             i_msi_ready,
    output logic [HartW-1:0] o_msi_hart,
    output logic [FileW-1:0] o_msi_file,
    output logic [IdW-1:0]   o_msi_id,
    output logic [15:0]      o_drop_cnt,
    output logic             o_busy
);

    localparam logic [31:0] SDiv   = 32'(NrVsFiles + 1);
    localparam logic [31:0] SPages = 32'(NrHarts * (NrVsFiles + 1));

    if (HartW > IMSIC_HART_W_MAX || FileW > IMSIC_FILE_W_MAX || IdW > IMSIC_ID_W_MAX) begin : g_bad_widths
        $error("imsic_setipnum_ctrl: configuration exceeds imsic_msi_t field widths");
    end
    if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
        $error("imsic_setipnum_ctrl: FifoDepth must be a power of two >= 2");
    end

    logic [31:0] m_page, s_page, id_raw;
    logic        m_hit, s_hit, le_hit, be_hit, id_ok, wr_ok;
    logic        accept, push, drop, pop, fifo_full, fifo_empty;
    imsic_msi_t  push_msg, head;
    logic        head_unused;
    logic        rsp_valid_q;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Wrapping subtraction: addresses below a base land on huge page numbers and miss.
    assign m_page = (i_req_addr - MBaseAddr) >> IMSIC_PAGE_SHIFT;
    assign s_page = (i_req_addr - SBaseAddr) >> IMSIC_PAGE_SHIFT;
    assign m_hit  = m_page < 32'(NrHarts);
    assign s_hit  = s_page < SPages;
    assign le_hit = (i_req_addr[11:0] == SETEIPNUM_LE_OFF);
    assign be_hit = (i_req_addr[11:0] == SETEIPNUM_BE_OFF);
    assign id_raw = be_hit ? imsic_bswap32(i_req_wdata) : i_req_wdata;
    assign id_ok  = (id_raw != 32'd0) && (id_raw < 32'(NrSources));
    assign wr_ok  = (m_hit || s_hit) && (le_hit || be_hit) && id_ok;

    assign accept = i_req_valid && o_req_ready;
    assign push   = accept && i_req_we && wr_ok;
    assign drop   = accept && i_req_we && !wr_ok;
    assign pop    = o_msi_valid && i_msi_ready;

    always_comb begin
        push_msg    = '0;
        push_msg.id = id_raw[IMSIC_ID_W_MAX-1:0];
        if (m_hit) begin
            push_msg.hart = m_page[IMSIC_HART_W_MAX-1:0];
            push_msg.file = '0;
        end else begin
            push_msg.hart = IMSIC_HART_W_MAX'(s_page / SDiv);
            push_msg.file = IMSIC_FILE_W_MAX'((s_page % SDiv) + 32'd1);
        end
    end

    imsic_msi_fifo #(
        .T     (imsic_msi_t),
        .Depth (FifoDepth)
    ) u_fifo (
        .i_clk   (i_clk),
        .ni_rst  (ni_rst),
        .i_push  (push),
        .i_data  (push_msg),
        .i_pop   (pop),
        .o_data  (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_req_ready = !fifo_full;
    assign o_msi_valid = !fifo_empty;
    assign o_busy      = !fifo_empty;
    assign o_msi_hart  = head.hart[HartW-1:0];
    assign o_msi_file  = head.file[FileW-1:0];
    assign o_msi_id    = head.id[IdW-1:0];
    assign head_unused = ^head;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = '0;
    assign o_drop_cnt  = drop_cnt_q;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            rsp_valid_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            rsp_valid_q <= accept;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_imsic_setipnum_ctrl.sv
// Bench for imsic_setipnum_ctrl: vector table, directed corner sequences and a random run
// against a queue-based reference model of the decode/buffer rules.
module tb_imsic_setipnum_ctrl;

    localparam logic [31:0] MB = 32'h2400_0000;
    localparam logic [31:0] SB = 32'h2800_0000;

    logic        i_clk = 1'b0;
    logic        ni_rst;
    logic        i_req_valid, i_req_we, i_msi_ready;
    logic [31:0] i_req_addr, i_req_wdata;
    logic        o_req_ready, o_rsp_valid, o_msi_valid, o_busy;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_msi_hart, o_msi_file;
    logic [5:0]  o_msi_id;
    logic [15:0] o_drop_cnt;

    always #5 i_clk = ~i_clk;

    imsic_setipnum_ctrl #(
        .NrHarts(4), .NrVsFiles(1), .NrSources(64),
        .MBaseAddr(MB), .SBaseAddr(SB), .FifoDepth(4)
    ) dut (
        .i_clk(i_clk), .ni_rst(ni_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata),
        .o_msi_valid(o_msi_valid), .i_msi_ready(i_msi_ready),
        .o_msi_hart(o_msi_hart), .o_msi_file(o_msi_file), .o_msi_id(o_msi_id),
        .o_drop_cnt(o_drop_cnt), .o_busy(o_busy)
    );

    typedef struct { int hart; int file; int id; } msg_t;
    typedef struct {
        bit        we;
        bit [31:0] addr;
        bit [31:0] data;
        bit        ok;
        int        hart, file, id, inc;
    } vec_t;

    msg_t exp_q[$];
    int   exp_drop;
    bit   exp_rsp;
    int   tests, fails;
    vec_t tbl[16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Reference decode straight from the address map, using plain integer arithmetic.
    function automatic bit ref_decode(input bit [31:0] a, input bit [31:0] d, output msg_t m);
        bit [31:0] off, id;
        int        page;
        m   = '{0, 0, 0};
        off = a % 4096;
        if (off == 0)      id = d;
        else if (off == 4) id = {d[7:0], d[15:8], d[23:16], d[31:24]};
        else               return 1'b0;
        if (id == 0 || id >= 64) return 1'b0;
        if (a >= MB && (a - MB) / 4096 < 4) begin
            m.hart = int'((a - MB) / 4096);
            m.file = 0;
        end else if (a >= SB && (a - SB) / 4096 < 8) begin
            page   = int'((a - SB) / 4096);
            m.hart = page / 2;
            m.file = page % 2 + 1;
        end else begin
            return 1'b0;
        end
        m.id = int'(id);
        return 1'b1;
    endfunction

    task automatic drive(input bit v, input bit we, input bit [31:0] a, input bit [31:0] d);
        i_req_valid = v;
        i_req_we    = we;
        i_req_addr  = a;
        i_req_wdata = d;
    endtask

    // One clock: check every output against the model mid-cycle, then advance the model.
    task automatic cycle(output bit acc);
        bit   pop, ok;
        msg_t m;
        @(negedge i_clk);
        chk("req_ready", o_req_ready, exp_q.size() < 4);
        chk("msi_valid", o_msi_valid, exp_q.size() != 0);
        chk("busy", o_busy, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("msi_hart", o_msi_hart, exp_q[0].hart);
            chk("msi_file", o_msi_file, exp_q[0].file);
            chk("msi_id", o_msi_id, exp_q[0].id);
        end
        chk("rsp_valid", o_rsp_valid, exp_rsp);
        chk("rsp_rdata", o_rsp_rdata, 0);
        chk("drop_cnt", o_drop_cnt, exp_drop);
        acc = i_req_valid && o_req_ready;
        pop = o_msi_valid && i_msi_ready;
        @(posedge i_clk);
        if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
        exp_rsp = acc;
        if (acc && i_req_we) begin
            ok = ref_decode(i_req_addr, i_req_wdata, m);
            if (ok) exp_q.push_back(m);
            else if (exp_drop < 65535) exp_drop++;
        end
        #1;
    endtask

    task automatic send(input bit we, input bit [31:0] a, input bit [31:0] d);
        bit acc;
        acc = 1'b0;
        drive(1'b1, we, a, d);
        for (int k = 0; k < 40; k++) begin
            cycle(acc);
            if (acc) break;
        end
        chk("send_accept", acc, 1);
        i_req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        i_req_valid = 1'b0;
        for (int k = 0; k < n; k++) cycle(acc);
    endtask

    task automatic check_reset(input string p);
        chk({p, "_req_ready"}, o_req_ready, 1);
        chk({p, "_rsp_valid"}, o_rsp_valid, 0);
        chk({p, "_rsp_rdata"}, o_rsp_rdata, 0);
        chk({p, "_msi_valid"}, o_msi_valid, 0);
        chk({p, "_msi_hart"}, o_msi_hart, 0);
        chk({p, "_msi_file"}, o_msi_file, 0);
        chk({p, "_msi_id"}, o_msi_id, 0);
        chk({p, "_drop_cnt"}, o_drop_cnt, 0);
        chk({p, "_busy"}, o_busy, 0);
    endtask

    // Called just after a rising edge; leaves the bench just after a rising edge.
    task automatic hit_reset(input string p);
        ni_rst = 1'b0;
        #1;
        check_reset({p, "_now"});
        @(posedge i_clk);
        #1;
        check_reset({p, "_hold"});
        i_req_valid = 1'b0;
        exp_q.delete();
        exp_drop = 0;
        exp_rsp  = 1'b0;
        @(negedge i_clk);
        ni_rst = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit        acc;
        int        n, base, waited;
        bit [31:0] a, d;
        tests = 0; fails = 0; exp_drop = 0; exp_rsp = 1'b0;
        ni_rst = 1'b0; i_msi_ready = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);

        tbl[0]  = '{1'b1, 32'h2400_1000, 32'h0000_0005, 1'b1, 1, 0, 5, 0};
        tbl[1]  = '{1'b1, 32'h2800_3004, 32'h0700_0000, 1'b1, 1, 2, 7, 0};
        tbl[2]  = '{1'b1, 32'h2800_0000, 32'h0000_003F, 1'b1, 0, 1, 63, 0};
        tbl[3]  = '{1'b1, 32'h2400_3000, 32'h0000_0001, 1'b1, 3, 0, 1, 0};
        tbl[4]  = '{1'b1, 32'h2800_7000, 32'h0000_002A, 1'b1, 3, 2, 42, 0};
        tbl[5]  = '{1'b1, 32'h2400_2004, 32'h0500_0000, 1'b1, 2, 0, 5, 0};
        tbl[6]  = '{1'b1, 32'h2400_0000, 32'h0000_0000, 1'b0, 0, 0, 0, 1};
        tbl[7]  = '{1'b1, 32'h2400_0000, 32'h0000_0040, 1'b0, 0, 0, 0, 1};
        tbl[8]  = '{1'b1, 32'h2400_0008, 32'h0000_0005, 1'b0, 0, 0, 0, 1};
        tbl[9]  = '{1'b1, 32'h2400_0000, 32'h8000_0001, 1'b0, 0, 0, 0, 1};
        tbl[10] = '{1'b1, 32'h2400_4000, 32'h0000_0005, 1'b0, 0, 0, 0, 1};
        tbl[11] = '{1'b1, 32'h2800_8000, 32'h0000_0005, 1'b0, 0, 0, 0, 1};
        tbl[12] = '{1'b1, 32'h2400_2004, 32'h0000_0005, 1'b0, 0, 0, 0, 1};
        tbl[13] = '{1'b1, 32'h23FF_F000, 32'h0000_0005, 1'b0, 0, 0, 0, 1};
        tbl[14] = '{1'b1, 32'h2800_1FFC, 32'h0000_0005, 1'b0, 0, 0, 0, 1};
        tbl[15] = '{1'b0, 32'h2400_1000, 32'h0000_0005, 1'b0, 0, 0, 0, 0};

        #12;
        check_reset("reset");
        @(negedge i_clk);
        ni_rst = 1'b1;
        @(posedge i_clk);
        #1;

        // Vector table: each write alone, checked the cycle after acceptance.
        i_msi_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            base = exp_drop;
            send(tbl[i].we, tbl[i].addr, tbl[i].data);
            chk($sformatf("tbl%0d_rsp", i), o_rsp_valid, 1);
            chk($sformatf("tbl%0d_valid", i), o_msi_valid, tbl[i].ok);
            if (tbl[i].ok) begin
                chk($sformatf("tbl%0d_hart", i), o_msi_hart, tbl[i].hart);
                chk($sformatf("tbl%0d_file", i), o_msi_file, tbl[i].file);
                chk($sformatf("tbl%0d_id", i), o_msi_id, tbl[i].id);
            end
            chk($sformatf("tbl%0d_drops", i), o_drop_cnt, base + tbl[i].inc);
            idle(1);
        end

        // Sustained push and pop across several pointer wraps.
        n = 0;
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 1'b1, MB + 32'((k % 4) * 4096), 32'(k + 1));
            cycle(acc);
            n += int'(acc);
        end
        i_req_valid = 1'b0;
        chk("stream_accepts", n, 12);
        idle(3);

        // Back-pressure: four writes fill the buffer, the fifth waits for a pop.
        i_msi_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(1'b1, SB + 32'(k * 4096), 32'(20 + k));
        chk("bp_ready_low", o_req_ready, 0);
        drive(1'b1, 1'b1, SB + 32'h7000, 32'd24);
        for (int k = 0; k < 2; k++) begin
            cycle(acc);
            chk("bp_stall", acc, 0);
        end
        i_msi_ready = 1'b1;
        waited = 0;
        acc    = 1'b0;
        while (!acc && waited < 10) begin
            cycle(acc);
            waited++;
        end
        chk("bp_5th_wait", waited, 2);
        idle(6);
        chk("bp_drained", o_busy, 0);

        // Random traffic against the reference model.
        acc = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!(i_req_valid && !acc)) begin
                case ($urandom_range(0, 3))
                    0: a = MB + 32'($urandom_range(0, 5) * 4096);
                    1: a = SB + 32'($urandom_range(0, 9) * 4096);
                    2: a = $urandom;
                    default: a = SB - 32'h1000;
                endcase
                case ($urandom_range(0, 5))
                    0, 1, 2: a[11:0] = 12'h000;
                    3, 4: a[11:0] = 12'h004;
                    default: a[11:0] = 12'hFFC;
                endcase
                case ($urandom_range(0, 2))
                    0: d = 32'($urandom_range(0, 70));
                    1: d = 32'($urandom_range(0, 70)) << 24;
                    default: d = $urandom;
                endcase
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, a, d);
            end
            i_msi_ready = ($urandom_range(0, 2) != 0);
            cycle(acc);
        end
        i_msi_ready = 1'b1;
        idle(6);

        // Reset mid-stream with three queued messages and two drops counted.
        @(negedge i_clk);
        hit_reset("pre");
        i_msi_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(1'b1, MB + 32'h1000, 32'(3 + k));
        send(1'b1, MB, 32'd0);
        send(1'b1, MB + 32'h8, 32'd5);
        chk("mid_drops", o_drop_cnt, 2);
        chk("mid_busy", o_busy, 1);
        drive(1'b1, 1'b1, MB, 32'd9);
        hit_reset("mid");
        i_msi_ready = 1'b1;
        send(1'b1, SB + 32'h5000, 32'd33);
        chk("post_valid", o_msi_valid, 1);
        chk("post_hart", o_msi_hart, 2);
        chk("post_file", o_msi_file, 2);
        chk("post_id", o_msi_id, 33);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
